// File: rtl/game_pkg.sv
// Shared game definitions: state encodings, cell codes and map geometry.
// Used by the judge, the character mover and the renderer.
package game_pkg;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_WAIT = 3'd1,
    ST_GAME = 3'd2,
    ST_WIN  = 3'd3,
    ST_LOSE = 3'd4
  } state_e;

  // Cell codes are kept as raw 3-bit values: codes 3..7 can appear in the
  // map and must behave like LINE, so an enum would not cover them.
  localparam logic [2:0] CELL_NONE     = 3'd0;
  localparam logic [2:0] CELL_LINE     = 3'd1;
  localparam logic [2:0] CELL_TERMINAL = 3'd2;

  localparam int MAP_W     = 20;
  localparam int MAP_H     = 15;
  localparam int CELL_BITS = 3;
  localparam int CELL_PX   = 16;

  localparam int MAP_BITS   = MAP_W * MAP_H * CELL_BITS;
  localparam int PIX_W      = MAP_W * CELL_PX;
  localparam int PIX_H      = MAP_H * CELL_PX;
  localparam int CELL_SHIFT = $clog2(CELL_PX);

endpackage

// File: rtl/cell_lookup.sv
// Registered pixel-position to cell-code stage: converts the character pixel
// position into a map cell, range-checks it and extracts that cell's code.
module cell_lookup
  import game_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [8:0]          i_pix_h,
  input  logic [8:0]          i_pix_v,
  input  logic [0:MAP_BITS-1] i_map,
  output logic [2:0]          o_cell_code
);

  logic [8:0] w_cell_h;
  logic [8:0] w_cell_v;
  logic       w_in_range;
  logic [9:0] w_idx;
  logic [9:0] w_base;
  logic [2:0] r_cell_code;

  assign w_cell_h   = i_pix_h >> CELL_SHIFT;
  assign w_cell_v   = i_pix_v >> CELL_SHIFT;
  assign w_in_range = (i_pix_h < 9'(PIX_W)) && (i_pix_v < 9'(PIX_H));
  assign w_idx      = 10'(w_cell_h) + 10'(w_cell_v) * 10'(MAP_W);
  assign w_base     = w_idx * 10'(CELL_BITS);

  // Capture the code under the character every cycle; off-map reads as NONE.
  // The map is ascending-indexed, so the +: select yields map[b] as the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cell_code <= CELL_NONE;
    end else if (w_in_range) begin
      // NOTE: sequential state uses non-blocking (<=) so every register
      // samples pre-edge values and simulation matches the synthesized flops.
      r_cell_code <= i_map[w_base +: CELL_BITS];
    end else begin
      r_cell_code <= CELL_NONE;
    end
  end

  assign o_cell_code = r_cell_code;

endmodule

// File: rtl/game_judge.sv
// Top-level game controller: owns the game state bus, runs the per-game
// countdown and declares WIN on a terminal cell or LOSE on timeout.
module game_judge
  import game_pkg::*;
#(
  parameter int         TICK_CNT   = 100_000_000,
  parameter logic [7:0] TIME_LIMIT = 8'd60
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [8:0]          charactor_h,
  input  logic [8:0]          charactor_v,
  input  logic [0:MAP_BITS-1] map,
  output logic [2:0]          state,
  output logic [7:0]          time_left
);

  localparam int            TW        = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CNT - 1);

  state_e        r_state;
  state_e        w_next_state;
  logic          r_start_d;
  logic          w_start_rise;
  logic [TW-1:0] r_tick;
  logic [7:0]    r_time_left;
  logic [2:0]    w_cell_code;
  logic          w_tick_done;
  logic          w_expire;

  cell_lookup u_cell_lookup (
    .clk         (clk),
    .rst         (rst),
    .i_pix_h     (charactor_h),
    .i_pix_v     (charactor_v),
    .i_map       (map),
    .o_cell_code (w_cell_code)
  );

  assign w_start_rise = start & ~r_start_d;
  assign w_tick_done  = (r_state == ST_GAME) && (r_tick == TICK_LAST);
  // A zero time limit expires on the very first tick, hence <= 1.
  assign w_expire     = w_tick_done && (r_time_left <= 8'd1);

  // Delay start by one cycle so only its rising edge is acted on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_start_d <= 1'b0;
    else     r_start_d <= start;
  end

  // Game state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_INIT;
    else     r_state <= w_next_state;
  end

  // Next-state logic; a terminal hit outranks a simultaneous timeout.
  always_comb begin
    // NOTE: default first so every path assigns w_next_state and no latch
    // is inferred.
    w_next_state = r_state;
    case (r_state)
      ST_INIT: w_next_state = ST_WAIT;
      ST_WAIT: if (w_start_rise) w_next_state = ST_GAME;
      ST_GAME: begin
        if (w_cell_code == CELL_TERMINAL) w_next_state = ST_WIN;
        else if (w_expire)                w_next_state = ST_LOSE;
      end
      ST_WIN,
      ST_LOSE: if (w_start_rise) w_next_state = ST_INIT;
      default: w_next_state = ST_INIT;
    endcase
  end

  // Countdown: ticks only in GAME, reloads in INIT/WAIT, frozen afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tick      <= '0;
      r_time_left <= TIME_LIMIT;
    end else begin
      case (r_state)
        ST_GAME: begin
          if (r_tick == TICK_LAST) begin
            r_tick <= '0;
            if (r_time_left != 8'd0) r_time_left <= r_time_left - 8'd1;
          end else begin
            r_tick <= r_tick + TW'(1);
          end
        end
        ST_INIT,
        ST_WAIT: begin
          r_tick      <= '0;
          r_time_left <= TIME_LIMIT;
        end
        default: r_tick <= '0;
      endcase
    end
  end

  assign state     = r_state;
  assign time_left = r_time_left;

endmodule

// File: tb/tb_game_judge.sv
// Self-checking bench for game_judge with a short countdown (4 cycles per
// second, 3 seconds per game). Expected state/time pairs are queued as
// stimulus is applied and compared once the DUT has clocked.
module tb_game_judge;
  import game_pkg::*;

  localparam int         TB_TICK  = 4;
  localparam logic [7:0] TB_LIMIT = 8'd3;

  typedef struct {
    logic [2:0] st;
    logic [7:0] tl;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [8:0]          pos_h;
  logic [8:0]          pos_v;
  logic [0:MAP_BITS-1] tb_map;
  logic [2:0]          state;
  logic [7:0]          time_left;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  game_judge #(
    .TICK_CNT   (TB_TICK),
    .TIME_LIMIT (TB_LIMIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .charactor_h (pos_h),
    .charactor_v (pos_v),
    .map         (tb_map),
    .state       (state),
    .time_left   (time_left)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic set_cell(input int h, input int v, input logic [2:0] code);
    int idx;
    idx = h + MAP_W * v;
    tb_map[idx*CELL_BITS +: CELL_BITS] = code;
  endtask

  task automatic build_map();
    for (int v = 0; v < MAP_H; v++)
      for (int h = 0; h < MAP_W; h++)
        set_cell(h, v, CELL_LINE);
    set_cell(12, 2, CELL_TERMINAL);  // reached at pixel (200,40)
    set_cell(0, 7, CELL_TERMINAL);   // aliases pixel (330,100) if unchecked
    set_cell(5, 5, 3'd5);            // code above TERMINAL behaves as LINE
  endtask

  // Reset, with start held high across release.
  task automatic test_reset();
    exp_t e;
    rst = 1'b1; start = 1'b1; pos_h = 9'd72; pos_v = 9'd72;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (state !== ST_INIT || time_left !== TB_LIMIT) begin
      n_errors++;
      $display("FAIL reset_state: got state=%0d time=%0d, want state=%0d time=%0d",
               state, time_left, ST_INIT, TB_LIMIT);
    end
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 4) start = 1'b0;
      exp_q.push_back('{ST_WAIT, TB_LIMIT});
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_checks++;
      if (state !== e.st || time_left !== e.tl) begin
        n_errors++;
        $display("FAIL reset_held_start c%0d: got state=%0d time=%0d, want state=%0d time=%0d",
                 c, state, time_left, e.st, e.tl);
      end
    end
  endtask

  // Countdown to LOSE on a LINE cell (including a code-5 cell), then restart.
  task automatic test_countdown_lose();
    exp_t e;
    pos_h = 9'd88; pos_v = 9'd88;  // cell (5,5), code 5
    start = 1'b1;
    for (int c = 0; c < 18; c++) begin
      if (c == 1)  start = 1'b0;
      if (c == 15) start = 1'b1;
      if (c == 16) start = 1'b0;
      if      (c < 4)   exp_q.push_back('{ST_GAME, 8'd3});
      else if (c < 8)   exp_q.push_back('{ST_GAME, 8'd2});
      else if (c < 12)  exp_q.push_back('{ST_GAME, 8'd1});
      else if (c < 15)  exp_q.push_back('{ST_LOSE, 8'd0});
      else if (c == 15) exp_q.push_back('{ST_INIT, 8'd0});
      else              exp_q.push_back('{ST_WAIT, TB_LIMIT});
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_checks++;
      if (state !== e.st || time_left !== e.tl) begin
        n_errors++;
        $display("FAIL countdown_lose c%0d: got state=%0d time=%0d, want state=%0d time=%0d",
                 c, state, time_left, e.st, e.tl);
      end
    end
    pos_h = 9'd72; pos_v = 9'd72;
  endtask

  // Move onto a TERMINAL cell mid-game: WIN two edges later, then restart.
  task automatic test_win();
    exp_t e;
    start = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c == 1) start = 1'b0;
      if (c == 2) begin pos_h = 9'd200; pos_v = 9'd40; end
      if (c == 6) start = 1'b1;
      if (c == 7) start = 1'b0;
      if      (c < 3)  exp_q.push_back('{ST_GAME, 8'd3});
      else if (c < 6)  exp_q.push_back('{ST_WIN, 8'd3});
      else if (c == 6) exp_q.push_back('{ST_INIT, 8'd3});
      else             exp_q.push_back('{ST_WAIT, TB_LIMIT});
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_checks++;
      if (state !== e.st || time_left !== e.tl) begin
        n_errors++;
        $display("FAIL win c%0d: got state=%0d time=%0d, want state=%0d time=%0d",
                 c, state, time_left, e.st, e.tl);
      end
    end
    pos_h = 9'd72; pos_v = 9'd72;
  endtask

  // Terminal registered on the same edge as the final decrement: WIN wins.
  task automatic test_win_priority();
    exp_t e;
    @(posedge clk); #1;  // let cell_code settle back to LINE
    start = 1'b1;
    for (int c = 0; c < 17; c++) begin
      if (c == 1)  start = 1'b0;
      if (c == 11) begin pos_h = 9'd200; pos_v = 9'd40; end
      if (c == 14) start = 1'b1;
      if (c == 15) start = 1'b0;
      if      (c < 4)   exp_q.push_back('{ST_GAME, 8'd3});
      else if (c < 8)   exp_q.push_back('{ST_GAME, 8'd2});
      else if (c < 12)  exp_q.push_back('{ST_GAME, 8'd1});
      else if (c < 14)  exp_q.push_back('{ST_WIN, 8'd0});
      else if (c == 14) exp_q.push_back('{ST_INIT, 8'd0});
      else              exp_q.push_back('{ST_WAIT, TB_LIMIT});
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_checks++;
      if (state !== e.st || time_left !== e.tl) begin
        n_errors++;
        $display("FAIL win_priority c%0d: got state=%0d time=%0d, want state=%0d time=%0d",
                 c, state, time_left, e.st, e.tl);
      end
    end
  endtask

  // Off-map position never wins; then asynchronous reset mid-game.
  task automatic test_off_map_and_async_reset();
    exp_t e;
    pos_h = 9'd330; pos_v = 9'd100;
    @(posedge clk); #1;
    start = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 1) start = 1'b0;
      if (c < 4) exp_q.push_back('{ST_GAME, 8'd3});
      else       exp_q.push_back('{ST_GAME, 8'd2});
      @(posedge clk); #1;
      e = exp_q.pop_front();
      n_checks++;
      if (state !== e.st || time_left !== e.tl) begin
        n_errors++;
        $display("FAIL off_map c%0d: got state=%0d time=%0d, want state=%0d time=%0d",
                 c, state, time_left, e.st, e.tl);
      end
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (state !== ST_INIT || time_left !== TB_LIMIT) begin
      n_errors++;
      $display("FAIL async_reset: got state=%0d time=%0d, want state=%0d time=%0d",
               state, time_left, ST_INIT, TB_LIMIT);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back('{ST_WAIT, TB_LIMIT});
    @(posedge clk); #1;
    e = exp_q.pop_front();
    n_checks++;
    if (state !== e.st || time_left !== e.tl) begin
      n_errors++;
      $display("FAIL after_reset: got state=%0d time=%0d, want state=%0d time=%0d",
               state, time_left, e.st, e.tl);
    end
  endtask

  initial begin
    build_map();
    test_reset();
    test_countdown_lose();
    test_win();
    test_win_priority();
    test_off_map_and_async_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/game_judge.md
# game_judge

Top-level game controller that sits directly upstream of the character mover. Owns the 3-bit game `state` bus (INIT/WAIT/GAME/WIN/LOSE) that the mover consumes. Consumes the mover's pixel position and the shared 20×15 cell map. Declares WIN when the character's cell is TERMINAL and LOSE when the per-game countdown expires.

## Interface
Parameters:
- `TICK_CNT`, default 100_000_000: clock cycles per countdown second.
- `TIME_LIMIT`, default 8'd60: seconds per game.

Ports:
- `clk`, in, 1: single system clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: start/restart button, level (debounced upstream); acted on at its rising edge only.
- `charactor_h`, in, 9: character x pixel, valid range 0–319.
- `charactor_v`, in, 9: character y pixel, valid range 0–239.
- `map`, in, [0:899]: 20×15 cells, 3 bits each.
  - Cell index `idx = h + 20*v`.
  - Code = {map[idx*3], map[idx*3+1], map[idx*3+2]}.
- `state`, out, 3: INIT=0, WAIT=1, GAME=2, WIN=3, LOSE=4.
- `time_left`, out, 8: remaining seconds.

## Operation
- Start edge: `start_rise = start & ~start_d`. `start_d` is a register, reset 0.
- Cell lookup (registered every cycle, all states):
  - `cell_h = charactor_h >> 4`, `cell_v = charactor_v >> 4`.
  - If `charactor_h ≥ 320` or `charactor_v ≥ 240`, `cell_code <= NONE`.
  - Otherwise `cell_code <=` the map code at that cell.
  - Reset value NONE.
- Cell codes: NONE=0, LINE=1, TERMINAL=2. Codes 3–7 are treated as LINE (not terminal).
- FSM:
  - INIT → WAIT unconditionally after one cycle. `start_rise` is ignored in INIT.
  - WAIT → GAME on `start_rise`.
  - GAME → WIN when `cell_code == TERMINAL`.
  - GAME → LOSE when the countdown decrements `time_left` from 1 to 0.
  - WIN or LOSE → INIT on `start_rise`.
  - GAME with simultaneous terminal hit and expiry: WIN has priority.
  - Unused encodings 5–7 → INIT.
- Countdown:
  - `tick_cnt` runs 0..TICK_CNT-1, and only in GAME. It clears to 0 in every other state and on entry to GAME.
  - At `tick_cnt == TICK_CNT-1`: `time_left` decrements by 1 and `tick_cnt` wraps to 0.
  - `time_left` loads TIME_LIMIT in INIT and WAIT. It is frozen in WIN and LOSE and never underflows below 0.
  - If TIME_LIMIT == 0, the game loses on the first tick.
- Reset values: `state`=INIT, `time_left`=TIME_LIMIT, `tick_cnt`=0, `cell_code`=NONE, `start_d`=0.
- Reset asserted mid-game: all of the above take their reset values immediately (asynchronous).
- `start` held high through reset release: produces a rising edge in the first cycle, which is discarded because the FSM is in INIT.

## Timing
- Position/map change at edge N → `cell_code` updated at edge N+1 → `state` = WIN at edge N+2. Two-cycle latency.
- `start` rising at edge N (sampled high, `start_d` low) → `state` changes at edge N+1.
- GAME entered at edge E → first decrement at edge E+TICK_CNT. Expiry at edge E+TIME_LIMIT·TICK_CNT, with `state` = LOSE on the same edge.
- All outputs are registered. No combinational input-to-output path.

## Structure
- Shared package `game_pkg`, also used by the character mover and the renderer:
  - state encodings INIT/WAIT/GAME/WIN/LOSE;
  - cell codes NONE/LINE/TERMINAL;
  - map dimensions MAP_W=20, MAP_H=15, CELL_BITS=3, CELL_PX=16.
- One sub-module, `cell_lookup`: registered position→cell-code stage (shift, range check, index, 3-bit extract).
- FSM and countdown live in `game_judge`.

## Test plan
- Reset, then hold `start`=1 across reset release:
  - `state` = 0 then 1; `time_left` = 60.
  - The held start does not enter GAME. Start must drop and rise again.
- With TICK_CNT=4, TIME_LIMIT=3, pulse `start` from WAIT, position held on a LINE cell:
  - `time_left` steps 3→2→1→0 every 4 cycles.
  - `state` = LOSE on the edge `time_left` reaches 0; it stays 0 and frozen.
- In GAME, move from (72,72) to pixel (200,40), where cell (12,2) is TERMINAL:
  - `state` = WIN exactly 2 cycles after the position change.
  - `time_left` frozen.
- Terminal hit registered in the same cycle as the final decrement (`time_left` 1→0):
  - `state` = WIN, not LOSE.
- Position (330,100) with map cell code arbitrary:
  - `cell_code` = NONE; no WIN.
- In WIN, pulse `start`:
  - INIT next cycle, WAIT the following cycle, `time_left` = TIME_LIMIT.
  - Assert `rst` mid-GAME: `state` = INIT immediately, without waiting for a clock edge.
